// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode types: instruction formats, opcodes, the decoded-field bundle
// and the pure decode function used by the decode stage.
package rv_decode_pkg;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_FENCE  = 7'h0f;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    // Immediate is kept as a 32-bit sign-extended value; the stage widens it to XLEN.
    typedef struct packed {
        logic [6:0]  opcode;
        fmt_e        fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        illegal;
    } dec_fields_t;

    function automatic dec_fields_t decode_inst(input logic [31:0] inst);
        dec_fields_t d;
        d        = '0;
        d.opcode = inst[6:0];
        // Every legal opcode ends in 2'b11, so a bad low pair falls into default.
        case (inst[6:0])
            OP_OP:                                        d.fmt = FMT_R;
            OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: d.fmt = FMT_I;
            OP_STORE:                                     d.fmt = FMT_S;
            OP_BRANCH:                                    d.fmt = FMT_B;
            OP_LUI, OP_AUIPC:                             d.fmt = FMT_U;
            OP_JAL:                                       d.fmt = FMT_J;
            default: begin
                d.fmt     = FMT_NONE;
                d.illegal = 1'b1;
            end
        endcase
        case (d.fmt)
            FMT_R: begin
                d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.rs2 = inst[24:20];
                d.funct3 = inst[14:12]; d.funct7 = inst[31:25];
            end
            FMT_I: begin
                d.rd = inst[11:7]; d.rs1 = inst[19:15]; d.funct3 = inst[14:12];
                d.imm = {{20{inst[31]}}, inst[31:20]};
            end
            FMT_S: begin
                d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.funct3 = inst[14:12];
                d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            FMT_B: begin
                d.rs1 = inst[19:15]; d.rs2 = inst[24:20]; d.funct3 = inst[14:12];
                d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            FMT_U: begin
                d.rd  = inst[11:7];
                d.imm = {inst[31:12], 12'b0};
            end
            FMT_J: begin
                d.rd  = inst[11:7];
                d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/rv_inst_decode.sv
// Purely combinational RV32I field extraction, a thin wrapper around decode_inst.
module rv_inst_decode
    import rv_decode_pkg::*;
(
    input  logic [31:0] i_inst,
    output dec_fields_t o_dec
);

    assign o_dec = decode_inst(i_inst);

endmodule

// File: rtl/decode_stage.sv
// Registered, ready/valid RV32I decode stage with an optional 2-entry skid buffer
// and flush for branch redirects.
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PC_W    = 32,
    parameter int SKID_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_fmt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        dec_fields_t     dec;
    } dec_bundle_t;

    skid_state_e r_state;
    dec_bundle_t r_out;
    dec_bundle_t r_skid;
    logic        r_out_valid;
    logic        r_in_ready;

    dec_fields_t w_dec;
    dec_bundle_t w_in;
    logic        w_acc;
    logic        w_cons;

    rv_inst_decode u_inst_decode (
        .i_inst (in_inst),
        .o_dec  (w_dec)
    );

    assign w_in   = {in_pc, w_dec};
    assign w_acc  = in_valid && in_ready && !flush;
    assign w_cons = r_out_valid && out_ready;

    generate
        if (SKID_EN != 0) begin : g_skid
            assign in_ready = r_in_ready;
        end else begin : g_single
            assign in_ready = !r_out_valid || out_ready;
        end
    endgenerate

    // NOTE: state and both bundle registers use non-blocking assignments so every
    // transition reads the pre-edge values; the bundles are reset too so out_* read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out       <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        r_out       <= w_in;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_cons) begin
                        r_out <= w_in;
                    end else if (w_acc) begin
                        r_skid     <= w_in;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_TWO;
                    end else if (w_cons) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_cons) begin
                        r_out      <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_EMPTY;
                end
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign out_pc      = r_out.pc;
    assign out_opcode  = r_out.dec.opcode;
    assign out_fmt     = r_out.dec.fmt;
    assign out_rd      = r_out.dec.rd;
    assign out_rs1     = r_out.dec.rs1;
    assign out_rs2     = r_out.dec.rs2;
    assign out_funct3  = r_out.dec.funct3;
    assign out_funct7  = r_out.dec.funct7;
    assign out_imm     = XLEN'($signed(r_out.dec.imm));
    assign out_illegal = r_out.dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed spec cases plus randomized traffic
// checked against an occupancy/queue model and an arithmetic immediate model.
module tb_decode_stage;
    import rv_decode_pkg::*;

    localparam int XLEN = 32;
    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_inst = '0;
    logic [PC_W-1:0] in_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [PC_W-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_fmt;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
    } txn_t;

    txn_t q[$];

    logic [6:0] legal_ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03,
                                   7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};

    decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .SKID_EN(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_fmt     (out_fmt),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_funct3  (out_funct3),
        .out_funct7  (out_funct7),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode of the word at the head of the queue, built from field
    // rules and value arithmetic on the signed instruction word.
    task automatic check_head(input txn_t t);
        logic [31:0] w;
        int          s;
        fmt_e        f;
        logic [31:0] e_imm;
        logic        u_rd, u_rs1, u_rs2, u_f7;
        w = t.inst;
        s = $signed(w);
        case (w[6:0])
            7'h33:                             f = FMT_R;
            7'h67, 7'h03, 7'h13, 7'h0f, 7'h73: f = FMT_I;
            7'h23:                             f = FMT_S;
            7'h63:                             f = FMT_B;
            7'h37, 7'h17:                      f = FMT_U;
            7'h6f:                             f = FMT_J;
            default:                           f = FMT_NONE;
        endcase
        case (f)
            FMT_I:   e_imm = s >>> 20;
            FMT_S:   e_imm = (s >>> 25) * 32 + ((s >> 7) & 31);
            FMT_B:   e_imm = (s < 0 ? -4096 : 0) + ((s >> 7) & 1) * 2048
                             + ((s >> 25) & 63) * 32 + ((s >> 8) & 15) * 2;
            FMT_U:   e_imm = w & 32'hFFFF_F000;
            FMT_J:   e_imm = (s < 0 ? -1048576 : 0) + ((s >> 12) & 255) * 4096
                             + ((s >> 20) & 1) * 2048 + ((s >> 21) & 1023) * 2;
            default: e_imm = '0;
        endcase
        u_rd  = f inside {FMT_R, FMT_I, FMT_U, FMT_J};
        u_rs1 = f inside {FMT_R, FMT_I, FMT_S, FMT_B};
        u_rs2 = f inside {FMT_R, FMT_S, FMT_B};
        u_f7  = (f == FMT_R);
        check("pc",      out_pc,      t.pc);
        check("opcode",  out_opcode,  w[6:0]);
        check("fmt",     out_fmt,     f);
        check("rd",      out_rd,      u_rd  ? w[11:7]  : 5'd0);
        check("rs1",     out_rs1,     u_rs1 ? w[19:15] : 5'd0);
        check("rs2",     out_rs2,     u_rs2 ? w[24:20] : 5'd0);
        check("funct3",  out_funct3,  u_rs1 ? w[14:12] : 3'd0);
        check("funct7",  out_funct7,  u_f7  ? w[31:25] : 7'd0);
        check("imm",     out_imm,     e_imm);
        check("illegal", out_illegal, f == FMT_NONE);
    endtask

    // One clock: check current outputs against the model, then advance the model
    // with the transfers that happen at the coming edge.
    task automatic do_cycle();
        logic acc, cons;
        check("out_valid", out_valid, q.size() != 0);
        check("in_ready",  in_ready,  q.size() < 2);
        if (out_valid && q.size() != 0) check_head(q[0]);
        acc  = in_valid && in_ready && !flush;
        cons = out_valid && out_ready;
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (cons && q.size() != 0) void'(q.pop_front());
            if (acc) q.push_back('{inst: in_inst, pc: in_pc});
        end
    endtask

    task automatic send_one(input logic [31:0] w, input logic [31:0] pc,
                            input logic [2:0] e_fmt, input logic [31:0] e_imm,
                            input logic e_ill);
        in_valid  = 1'b1;
        in_inst   = w;
        in_pc     = pc;
        out_ready = 1'b1;
        flush     = 1'b0;
        do_cycle();
        in_valid = 1'b0;
        check("dir_valid",   out_valid,   1'b1);
        check("dir_fmt",     out_fmt,     e_fmt);
        check("dir_imm",     out_imm,     e_imm);
        check("dir_illegal", out_illegal, e_ill);
        do_cycle();
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) != 0) w[6:0] = legal_ops[$urandom_range(0, 10)];
        return w;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed decode cases
        send_one(32'hFFF0_0093, 32'h0000_1000, FMT_I, 32'hFFFF_FFFF, 1'b0);
        send_one(32'h0020_8663, 32'h0000_1004, FMT_B, 32'd12,        1'b0);
        send_one(32'hFE11_2E23, 32'h0000_1008, FMT_S, 32'hFFFF_FFFC, 1'b0);
        send_one(32'h8000_00EF, 32'h0000_100C, FMT_J, 32'hFFF0_0000, 1'b0);
        send_one(32'h1234_5037, 32'h0000_1010, FMT_U, 32'h1234_5000, 1'b0);
        send_one(32'h0000_007F, 32'h0000_1014, FMT_NONE, 32'd0,     1'b1);
        send_one(32'h0000_0010, 32'h0000_1018, FMT_NONE, 32'd0,     1'b1);

        // Stall: three words offered, only two fit
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_inst = rand_word();
            in_pc   = 32'h2000 + 4 * i;
            do_cycle();
        end
        check("stall_in_ready", in_ready, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) do_cycle();

        // Flush while full with a word offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_inst = rand_word();
            in_pc   = 32'h3000 + 4 * i;
            do_cycle();
        end
        flush   = 1'b1;
        in_inst = 32'h0000_0033;
        in_pc   = 32'hDEAD_0000;
        do_cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready",  in_ready,  1'b1);
        out_ready = 1'b1;
        repeat (2) do_cycle();

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_inst   = rand_word();
            in_pc     = $urandom;
            do_cycle();
        end

        // Asynchronous reset mid-stream while a bundle is held
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'hFFF0_0093;
        in_pc     = 32'h0000_4000;
        do_cycle();
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid,   1'b0);
        check("rst_in_ready",  in_ready,    1'b1);
        check("rst_pc",        out_pc,      '0);
        check("rst_opcode",    out_opcode,  '0);
        check("rst_rd",        out_rd,      '0);
        check("rst_imm",       out_imm,     '0);
        check("rst_illegal",   out_illegal, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();

        // Post-reset traffic still flows
        send_one(32'h1234_5037, 32'h0000_5000, FMT_U, 32'h1234_5000, 1'b0);
        out_ready = 1'b1;
        repeat (3) do_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
